// File: rtl/csc_pkg.sv
// Shared widths, terminator codes and FSM encoding for the CSC input-activation
// global-buffer slice.
package csc_pkg;

  localparam int unsigned CSC_ADDR_WIDTH  = 7;
  localparam int unsigned CSC_COUNT_WIDTH = 4;
  localparam int unsigned CSC_DATA_WIDTH  = 8;
  localparam int unsigned CSC_WORD_WIDTH  = CSC_DATA_WIDTH + CSC_COUNT_WIDTH;

  localparam logic [CSC_ADDR_WIDTH-1:0] CSC_ADDR_TERM     = '0;
  localparam logic [CSC_WORD_WIDTH-1:0] CSC_DATA_TERM     = '0;
  localparam logic [CSC_ADDR_WIDTH-1:0] CSC_ADDR_ZERO_COL = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FULL,
    ST_DRAIN
  } state_t;

  function automatic logic is_zero_col(input logic [CSC_ADDR_WIDTH-1:0] a);
    return a == CSC_ADDR_ZERO_COL;
  endfunction

endpackage

// File: rtl/csc_iact_glb_bank_if.sv
// Write (encoder side) and read (PE side) handshake bundle of one GLB bank.
interface csc_iact_glb_bank_if #(
  parameter int unsigned ADDR_WIDTH = csc_pkg::CSC_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH = csc_pkg::CSC_WORD_WIDTH
);
  logic                  addr_in_valid;
  logic                  addr_in_ready;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [WORD_WIDTH-1:0] data_in;
  logic                  addr_out_valid;
  logic                  addr_out_ready;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic [WORD_WIDTH-1:0] data_out;

  modport master (
    output addr_in_valid, addr_in, data_in_valid, data_in,
           addr_out_ready, data_out_ready,
    input  addr_in_ready, data_in_ready,
           addr_out_valid, addr_out, data_out_valid, data_out
  );

  modport slave (
    input  addr_in_valid, addr_in, data_in_valid, data_in,
           addr_out_ready, data_out_ready,
    output addr_in_ready, data_in_ready,
           addr_out_valid, addr_out, data_out_valid, data_out
  );
endinterface

// File: rtl/csc_glb_read_stream.sv
// One CSC stream store: memory, saturating write pointer, terminator tracking
// and a replay path (registered memory read feeding a 2-entry skid buffer).
module csc_glb_read_stream #(
  parameter int unsigned      WIDTH = 7,
  parameter int unsigned      DEPTH = 16,
  parameter logic [WIDTH-1:0] TERM  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             term_seen,
  output logic             term_hit,
  output logic             drop,
  input  logic             rd_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             drained
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, term_idx, issue_addr;
  logic             is_term, wr_full, store;
  logic             reading, issue, issue_ok;
  logic             rd_q_valid, rd_q_last;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] ent_data [2];
  logic [1:0]       ent_last;
  logic             head;
  logic [1:0]       cnt, occ;
  logic             pop, pop_last, drained_q;

  assign is_term  = wr_data == TERM;
  assign wr_full  = wr_ptr == PW'(DEPTH - 1);
  assign store    = wr_en & (is_term | ~wr_full);
  assign term_hit = wr_en & is_term;
  assign drop     = wr_en & ~is_term & wr_full;

  always_ff @(posedge clock) begin
    if (store) mem[wr_ptr] <= wr_data;
  end

  assign out_valid = cnt != 2'd0;
  assign out_data  = ent_data[head];
  assign pop       = out_valid & out_ready;
  assign pop_last  = pop & ent_last[head];
  assign drained   = drained_q | pop_last;

  // Words buffered plus the one in flight must never exceed the two skid slots.
  assign occ        = cnt + 2'(rd_q_valid) - 2'(pop);
  assign issue_ok   = occ < 2'd2;
  assign issue_addr = rd_start ? '0 : rd_ptr;
  assign issue      = ~flush & (rd_start | (reading & issue_ok));

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr      <= '0;
      term_seen   <= 1'b0;
      term_idx    <= '0;
      rd_ptr      <= '0;
      reading     <= 1'b0;
      rd_q_valid  <= 1'b0;
      rd_q_last   <= 1'b0;
      rd_q        <= '0;
      ent_data[0] <= '0;
      ent_data[1] <= '0;
      ent_last    <= '0;
      head        <= 1'b0;
      cnt         <= '0;
      drained_q   <= 1'b0;
    end else begin
      if (wr_en && !wr_full) wr_ptr <= wr_ptr + PW'(1);
      if (store && is_term) begin
        term_seen <= 1'b1;
        term_idx  <= wr_ptr;
      end

      if (rd_start) begin
        reading   <= 1'b1;
        drained_q <= 1'b0;
      end
      if (issue) begin
        rd_ptr    <= issue_addr + PW'(1);
        rd_q      <= mem[issue_addr];
        rd_q_last <= issue_addr == term_idx;
        if (issue_addr == term_idx) reading <= 1'b0;
      end
      rd_q_valid <= issue;

      if (rd_q_valid) begin
        ent_data[head ^ cnt[0]] <= rd_q;
        ent_last[head ^ cnt[0]] <= rd_q_last;
      end
      if (pop) head <= ~head;
      cnt <= cnt + 2'(rd_q_valid) - 2'(pop);
      if (pop_last) drained_q <= 1'b1;
    end
  end
endmodule

// File: rtl/csc_iact_glb_bank.sv
// GLB bank holding one compressed input-activation vector: fills from the CSC
// encoder, replays on read_start, and empties on clear without touching memory.
module csc_iact_glb_bank
  import csc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = CSC_ADDR_WIDTH,
  parameter int unsigned COUNT_WIDTH = CSC_COUNT_WIDTH,
  parameter int unsigned DATA_WIDTH  = CSC_DATA_WIDTH,
  parameter int unsigned ADDR_DEPTH  = 16,
  parameter int unsigned DATA_DEPTH  = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                read_start,
  csc_iact_glb_bank_if.slave  bus,
  output logic                vector_ready,
  output logic                overflow,
  output logic                busy
);
  localparam int unsigned WORD_WIDTH = DATA_WIDTH + COUNT_WIDTH;

  state_t state, state_next;
  logic   write_open, start_ok, drain_finish, flush;
  logic   a_acc, d_acc;
  logic   a_term_seen, d_term_seen, a_term_hit, d_term_hit;
  logic   a_drop, d_drop, a_drained, d_drained;

  assign write_open = (state == ST_IDLE) || (state == ST_FILL);

  // During clear both streams look ready so the encoder can flush into the bank.
  assign bus.addr_in_ready = clear | (write_open & ~a_term_seen);
  assign bus.data_in_ready = clear | (write_open & ~d_term_seen);

  assign a_acc = bus.addr_in_valid & bus.addr_in_ready & ~clear;
  assign d_acc = bus.data_in_valid & bus.data_in_ready & ~clear;

  assign start_ok     = (state == ST_FULL) & read_start & ~clear;
  assign drain_finish = (state == ST_DRAIN) & a_drained & d_drained;
  assign flush        = clear | drain_finish;

  csc_glb_read_stream #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (ADDR_DEPTH),
    .TERM  (ADDR_WIDTH'(CSC_ADDR_TERM))
  ) u_addr (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .wr_en     (a_acc),
    .wr_data   (bus.addr_in),
    .term_seen (a_term_seen),
    .term_hit  (a_term_hit),
    .drop      (a_drop),
    .rd_start  (start_ok),
    .out_valid (bus.addr_out_valid),
    .out_ready (bus.addr_out_ready),
    .out_data  (bus.addr_out),
    .drained   (a_drained)
  );

  csc_glb_read_stream #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (DATA_DEPTH),
    .TERM  (WORD_WIDTH'(CSC_DATA_TERM))
  ) u_data (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .wr_en     (d_acc),
    .wr_data   (bus.data_in),
    .term_seen (d_term_seen),
    .term_hit  (d_term_hit),
    .drop      (d_drop),
    .rd_start  (start_ok),
    .out_valid (bus.data_out_valid),
    .out_ready (bus.data_out_ready),
    .out_data  (bus.data_out),
    .drained   (d_drained)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_FILL: begin
        if ((a_term_seen | a_term_hit) && (d_term_seen | d_term_hit))
          state_next = ST_FULL;
        else if (a_acc || d_acc)
          state_next = ST_FILL;
      end
      ST_FULL:  if (read_start) state_next = ST_DRAIN;
      ST_DRAIN: if (a_drained && d_drained) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset || clear || start_ok) overflow <= 1'b0;
    else if (a_drop || d_drop)      overflow <= 1'b1;
  end

  assign vector_ready = state == ST_FULL;
  assign busy         = (state == ST_FILL) || (state == ST_DRAIN);
endmodule

// File: tb/tb_csc_iact_glb_bank.sv
// Directed bench for csc_iact_glb_bank: fill, replay, back-pressure, overflow,
// clear and ignored read_start.
module tb_csc_iact_glb_bank;
  logic clock = 1'b0;
  logic reset, clear, read_start;
  logic vector_ready, overflow, busy;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_a [32];
  logic [31:0] exp_d [32];

  csc_iact_glb_bank_if bus ();

  csc_iact_glb_bank #(
    .ADDR_WIDTH  (7),
    .COUNT_WIDTH (4),
    .DATA_WIDTH  (8),
    .ADDR_DEPTH  (16),
    .DATA_DEPTH  (128)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .read_start   (read_start),
    .bus          (bus.slave),
    .vector_ready (vector_ready),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [6:0] a, input logic dv, input logic [11:0] d);
    bus.addr_in_valid = av;
    bus.addr_in       = a;
    bus.data_in_valid = dv;
    bus.data_in       = d;
  endtask

  // Consumes a replay; every valid word must match the next expected word.
  task automatic drain(input int n_a, input int n_d, input bit toggle);
    int ai = 0;
    int di = 0;
    int k  = 0;
    while ((ai < n_a || di < n_d) && k < 60) begin
      bus.addr_out_ready = toggle ? (k % 2 == 0) : 1'b1;
      bus.data_out_ready = 1'b1;
      if (k < n_d) chk("data_streaming", 32'(bus.data_out_valid), 1);
      if (bus.addr_out_valid) begin
        if (ai < n_a) chk("addr_out_word", 32'(bus.addr_out), exp_a[ai]);
        else          chk("addr_extra_valid", 32'(bus.addr_out_valid), 0);
        if (bus.addr_out_ready) ai++;
      end
      if (bus.data_out_valid) begin
        if (di < n_d) chk("data_out_word", 32'(bus.data_out), exp_d[di]);
        else          chk("data_extra_valid", 32'(bus.data_out_valid), 0);
        di++;
      end
      step();
      k++;
    end
    chk("addr_word_count", ai, n_a);
    chk("data_word_count", di, n_d);
    chk("drain_busy_low", 32'(busy), 0);
    chk("drain_addr_valid_low", 32'(bus.addr_out_valid), 0);
    chk("drain_data_valid_low", 32'(bus.data_out_valid), 0);
    chk("drain_vr_low", 32'(vector_ready), 0);
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    read_start = 1'b0;
    drive(0, '0, 0, '0);
    bus.addr_out_ready = 1'b1;
    bus.data_out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset values
    chk("rst_addr_in_ready", 32'(bus.addr_in_ready), 1);
    chk("rst_data_in_ready", 32'(bus.data_in_ready), 1);
    chk("rst_addr_out_valid", 32'(bus.addr_out_valid), 0);
    chk("rst_data_out_valid", 32'(bus.data_out_valid), 0);
    chk("rst_addr_out", 32'(bus.addr_out), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    chk("rst_vector_ready", 32'(vector_ready), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);

    // read_start in IDLE is ignored
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    step();
    step();
    chk("idle_read_busy", 32'(busy), 0);
    chk("idle_read_addr_valid", 32'(bus.addr_out_valid), 0);
    chk("idle_read_data_valid", 32'(bus.data_out_valid), 0);

    // Basic vector, with an ignored read_start while filling
    drive(1, 7'd2, 1, 12'h050);
    step();
    chk("fill_busy", 32'(busy), 1);
    chk("fill_vr", 32'(vector_ready), 0);
    drive(1, 7'd3, 1, 12'hFF1);
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    drive(1, 7'd0, 1, 12'h032);
    step();
    chk("addr_term_ready_low", 32'(bus.addr_in_ready), 0);
    chk("data_ready_still_high", 32'(bus.data_in_ready), 1);
    chk("fill_vr_before_last_term", 32'(vector_ready), 0);
    chk("fill_read_ignored_busy", 32'(busy), 1);
    chk("fill_read_ignored_valid", 32'(bus.addr_out_valid), 0);
    drive(0, '0, 1, 12'h000);
    step();
    drive(0, '0, 0, '0);
    chk("full_vr", 32'(vector_ready), 1);
    chk("full_busy", 32'(busy), 0);
    chk("full_data_ready_low", 32'(bus.data_in_ready), 0);

    exp_a[0] = 32'h2;   exp_a[1] = 32'h3;   exp_a[2] = 32'h0;
    exp_d[0] = 32'h050; exp_d[1] = 32'hFF1; exp_d[2] = 32'h032; exp_d[3] = 32'h000;
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    chk("lat1_addr_valid", 32'(bus.addr_out_valid), 0);
    chk("lat1_data_valid", 32'(bus.data_out_valid), 0);
    chk("drain_busy", 32'(busy), 1);
    step();
    chk("lat2_addr_valid", 32'(bus.addr_out_valid), 1);
    chk("lat2_data_valid", 32'(bus.data_out_valid), 1);
    drain(3, 4, 1'b1);
    chk("after_drain_addr_ready", 32'(bus.addr_in_ready), 1);

    // Simultaneous terminators, then clear mid-DRAIN
    drive(1, 7'd5, 1, 12'h123);
    step();
    drive(1, 7'd0, 1, 12'h000);
    step();
    drive(0, '0, 0, '0);
    chk("simul_vr", 32'(vector_ready), 1);
    chk("simul_addr_ready_low", 32'(bus.addr_in_ready), 0);
    chk("simul_data_ready_low", 32'(bus.data_in_ready), 0);
    bus.addr_out_ready = 1'b0;
    bus.data_out_ready = 1'b0;
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    step();
    step();
    chk("hold_addr_valid", 32'(bus.addr_out_valid), 1);
    chk("hold_addr_out", 32'(bus.addr_out), 32'h5);
    chk("hold_data_out", 32'(bus.data_out), 32'h123);
    clear = 1'b1;
    step();
    chk("clr_drain_addr_valid", 32'(bus.addr_out_valid), 0);
    chk("clr_drain_data_valid", 32'(bus.data_out_valid), 0);
    chk("clr_drain_busy", 32'(busy), 0);
    chk("clr_drain_vr", 32'(vector_ready), 0);
    clear = 1'b0;
    bus.addr_out_ready = 1'b1;
    bus.data_out_ready = 1'b1;
    step();
    chk("post_clr_addr_ready", 32'(bus.addr_in_ready), 1);
    chk("post_clr_data_ready", 32'(bus.data_in_ready), 1);

    // Clear held for 3 cycles, then with terminators offered (must be discarded)
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clr_hold_addr_ready", 32'(bus.addr_in_ready), 1);
      chk("clr_hold_data_ready", 32'(bus.data_in_ready), 1);
      chk("clr_hold_busy", 32'(busy), 0);
      chk("clr_hold_vr", 32'(vector_ready), 0);
    end
    drive(1, 7'd0, 1, 12'h000);
    step();
    clear = 1'b0;
    drive(0, '0, 0, '0);
    step();
    chk("clr_discard_addr_ready", 32'(bus.addr_in_ready), 1);
    chk("clr_discard_vr", 32'(vector_ready), 0);
    chk("clr_discard_busy", 32'(busy), 0);

    // Overflow: 20 address words into a 16-entry memory
    for (int i = 0; i < 20; i++) begin
      drive(1, 7'(i + 1), (i < 2), (i == 0) ? 12'h011 : 12'h000);
      step();
      if (i == 14) chk("ovf_not_yet", 32'(overflow), 0);
      if (i == 15) chk("ovf_set", 32'(overflow), 1);
    end
    chk("ovf_data_ready_low", 32'(bus.data_in_ready), 0);
    drive(1, 7'd0, 0, '0);
    step();
    drive(0, '0, 0, '0);
    chk("ovf_vr", 32'(vector_ready), 1);
    chk("ovf_sticky", 32'(overflow), 1);
    for (int i = 0; i < 15; i++) exp_a[i] = 32'(i + 1);
    exp_a[15] = 32'h0;
    exp_d[0]  = 32'h011;
    exp_d[1]  = 32'h000;
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    chk("ovf_cleared_by_read", 32'(overflow), 0);
    step();
    drain(16, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
